// File: rtl/id_ex_reg.sv
// ID->EX pipeline register for the 5-stage MIPS core.
// Captures decoder control bits and ID operands and presents them to EX one
// clock later. Supports stall (hold everything) and flush (load a bubble).
// Invalid slots (valid_d=0) load with every control bit cleared.
// Optional feature macro: IDEX_BUBBLE_CNT_EN adds a saturating 32-bit
// bubble counter output (bubble_cnt).
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic              regwrite_d,
    input  logic              regdst_d,
    input  logic              alusrc_d,
    input  logic              branch_d,
    input  logic              memwrite_d,
    input  logic              memtoreg_d,
    input  logic              jump_d,
    input  logic [ALUC_W-1:0] alucontrol_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] signimm_d,
    input  logic [DATA_W-1:0] pcplus4_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rd_d,
    output logic              valid_e,
    output logic              regwrite_e,
    output logic              regdst_e,
    output logic              alusrc_e,
    output logic              branch_e,
    output logic              memwrite_e,
    output logic              memtoreg_e,
    output logic              jump_e,
    output logic [ALUC_W-1:0] alucontrol_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] signimm_e,
    output logic [DATA_W-1:0] pcplus4_e,
    output logic [REG_AW-1:0] rs_e,
    output logic [REG_AW-1:0] rt_e,
    output logic [REG_AW-1:0] rd_e
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              regdst;
        logic              alusrc;
        logic              branch;
        logic              memwrite;
        logic              memtoreg;
        logic              jump;
        logic [ALUC_W-1:0] alucontrol;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signimm;
        logic [DATA_W-1:0] pcplus4;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } stage_t;

    stage_t load_val;
    stage_t stage_d;
    stage_t stage_q;

    // Value loaded on a normal edge; invalid slots carry data but no control.
    always_comb begin
        load_val            = '0;
        load_val.valid      = valid_d;
        load_val.rd1        = rd1_d;
        load_val.rd2        = rd2_d;
        load_val.signimm    = signimm_d;
        load_val.pcplus4    = pcplus4_d;
        load_val.rs         = rs_d;
        load_val.rt         = rt_d;
        load_val.rd         = rd_d;
        if (valid_d) begin
            load_val.regwrite   = regwrite_d;
            load_val.regdst     = regdst_d;
            load_val.alusrc     = alusrc_d;
            load_val.branch     = branch_d;
            load_val.memwrite   = memwrite_d;
            load_val.memtoreg   = memtoreg_d;
            load_val.jump       = jump_d;
            load_val.alucontrol = alucontrol_d;
        end
    end

    // Next-state select: flush beats stall beats load.
    always_comb begin
        stage_d = stage_q;
        if (flush_e) begin
            stage_d = '0;
        end else if (!stall_e) begin
            stage_d = load_val;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_e      = stage_q.valid;
    assign regwrite_e   = stage_q.regwrite;
    assign regdst_e     = stage_q.regdst;
    assign alusrc_e     = stage_q.alusrc;
    assign branch_e     = stage_q.branch;
    assign memwrite_e   = stage_q.memwrite;
    assign memtoreg_e   = stage_q.memtoreg;
    assign jump_e       = stage_q.jump;
    assign alucontrol_e = stage_q.alucontrol;
    assign rd1_e        = stage_q.rd1;
    assign rd2_e        = stage_q.rd2;
    assign signimm_e    = stage_q.signimm;
    assign pcplus4_e    = stage_q.pcplus4;
    assign rs_e         = stage_q.rs;
    assign rt_e         = stage_q.rt;
    assign rd_e         = stage_q.rd;

`ifdef IDEX_BUBBLE_CNT_EN
    logic        bubble_ev;
    logic [31:0] bubble_cnt_d;
    logic [31:0] bubble_cnt_q;

    // A bubble enters EX on a flush, or on an unstalled load of an invalid slot.
    always_comb begin
        bubble_ev    = flush_e | (!stall_e & !valid_d);
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ev && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Saturating bubble counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed steps plus a short random run. Expected
// register contents are computed from a bench-side reference model when each
// step is driven, queued, and compared once the clock edge has passed.
// Build with IDEX_BUBBLE_CNT_EN defined to also exercise bubble_cnt.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        regdst;
        logic        alusrc;
        logic        branch;
        logic        memwrite;
        logic        memtoreg;
        logic        jump;
        logic [2:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [31:0] pcplus4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } fld_t;

    logic  clk;
    logic  rst;
    logic  stall_e;
    logic  flush_e;
    fld_t  din;
    fld_t  obs;

    logic        valid_e, regwrite_e, regdst_e, alusrc_e, branch_e;
    logic        memwrite_e, memtoreg_e, jump_e;
    logic [2:0]  alucontrol_e;
    logic [31:0] rd1_e, rd2_e, signimm_e, pcplus4_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [31:0] bubble_cnt_obs;

    int n_tests = 0;
    int n_fail  = 0;

    fld_t        exp_state;
    logic [31:0] exp_cnt;
    fld_t        sb_q[$];
    logic [31:0] sb_cnt_q[$];

    id_ex_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .valid_d      (din.valid),
        .regwrite_d   (din.regwrite),
        .regdst_d     (din.regdst),
        .alusrc_d     (din.alusrc),
        .branch_d     (din.branch),
        .memwrite_d   (din.memwrite),
        .memtoreg_d   (din.memtoreg),
        .jump_d       (din.jump),
        .alucontrol_d (din.aluc),
        .rd1_d        (din.rd1),
        .rd2_d        (din.rd2),
        .signimm_d    (din.signimm),
        .pcplus4_d    (din.pcplus4),
        .rs_d         (din.rs),
        .rt_d         (din.rt),
        .rd_d         (din.rd),
        .valid_e      (valid_e),
        .regwrite_e   (regwrite_e),
        .regdst_e     (regdst_e),
        .alusrc_e     (alusrc_e),
        .branch_e     (branch_e),
        .memwrite_e   (memwrite_e),
        .memtoreg_e   (memtoreg_e),
        .jump_e       (jump_e),
        .alucontrol_e (alucontrol_e),
        .rd1_e        (rd1_e),
        .rd2_e        (rd2_e),
        .signimm_e    (signimm_e),
        .pcplus4_e    (pcplus4_e),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .rd_e         (rd_e)
`ifdef IDEX_BUBBLE_CNT_EN
        ,
        .bubble_cnt   (bubble_cnt_obs)
`endif
    );

`ifndef IDEX_BUBBLE_CNT_EN
    assign bubble_cnt_obs = '0;
`endif

    assign obs = {valid_e, regwrite_e, regdst_e, alusrc_e, branch_e, memwrite_e,
                  memtoreg_e, jump_e, alucontrol_e, rd1_e, rd2_e, signimm_e,
                  pcplus4_e, rs_e, rt_e, rd_e};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fld_t model(fld_t prev, logic st, logic fl, fld_t d);
        fld_t n;
        if (fl) return '0;
        if (st) return prev;
        n = d;
        if (!d.valid) begin
            n.regwrite = 1'b0; n.regdst   = 1'b0; n.alusrc = 1'b0; n.branch = 1'b0;
            n.memwrite = 1'b0; n.memtoreg = 1'b0; n.jump   = 1'b0; n.aluc   = 3'b000;
        end
        return n;
    endfunction

    task automatic check(string tag, fld_t o, fld_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check32(string tag, logic [31:0] o, logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive one cycle of stimulus, queue the model result, compare after the edge.
    task automatic step(string tag, logic st, logic fl, fld_t d);
        fld_t        e;
        logic [31:0] ec;
        stall_e = st;
        flush_e = fl;
        din     = d;
        exp_state = model(exp_state, st, fl, d);
        if ((fl || (!st && !d.valid)) && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        sb_q.push_back(exp_state);
        sb_cnt_q.push_back(exp_cnt);
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        ec = sb_cnt_q.pop_front();
        check(tag, obs, e);
`ifdef IDEX_BUBBLE_CNT_EN
        check32({tag, "_cnt"}, bubble_cnt_obs, ec);
`else
        ec = ec;
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst();
        #2;
        rst = 1'b1;
        #1;
        exp_state = '0;
        exp_cnt   = '0;
        check("reset_async", obs, '0);
`ifdef IDEX_BUBBLE_CNT_EN
        check32("reset_async_cnt", bubble_cnt_obs, 32'd0);
`endif
        #1;
        rst = 1'b0;
    endtask

    function automatic fld_t rand_fld();
        fld_t f;
        f.valid    = 1'($urandom_range(0, 3) != 0);
        f.regwrite = 1'($urandom);
        f.regdst   = 1'($urandom);
        f.alusrc   = 1'($urandom);
        f.branch   = 1'($urandom);
        f.memwrite = 1'($urandom);
        f.memtoreg = 1'($urandom);
        f.jump     = 1'($urandom);
        f.aluc     = 3'($urandom);
        f.rd1      = $urandom;
        f.rd2      = $urandom;
        f.signimm  = $urandom;
        f.pcplus4  = $urandom;
        f.rs       = 5'($urandom);
        f.rt       = 5'($urandom);
        f.rd       = 5'($urandom);
        return f;
    endfunction

    initial begin
        fld_t f;
        fld_t all1;
        rst     = 1'b1;
        stall_e = 1'b0;
        flush_e = 1'b0;
        din     = '0;
        exp_state = '0;
        exp_cnt   = '0;
        #2;
        check("power_on_reset", obs, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pass-through
        f = '0;
        f.valid = 1'b1; f.regwrite = 1'b1; f.aluc = 3'b010; f.rd1 = 32'h1234_5678;
        f.pcplus4 = 32'h0040_0004; f.rs = 5'd3; f.rt = 5'd9; f.rd = 5'd17;
        step("pass_through", 1'b0, 1'b0, f);
        check32("pass_rd1", rd1_e, 32'h1234_5678);
        check32("pass_regwrite", {31'd0, regwrite_e}, 32'd1);
        check32("pass_aluc", {29'd0, alucontrol_e}, 32'd2);

        // Async reset with every input non-zero
        all1 = '1;
        all1.rd1 = 32'hDEAD_BEEF; all1.rd2 = 32'hCAFE_F00D;
        step("load_all_ones", 1'b0, 1'b0, all1);
        pulse_rst();

        // Stall holds for three edges, release loads the new value
        f = '0; f.valid = 1'b1; f.rd1 = 32'hA; f.regwrite = 1'b1;
        step("stall_load_a", 1'b0, 1'b0, f);
        f.rd1 = 32'hB; f.regwrite = 1'b0; f.memwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b1, 1'b0, f);
            check32("stall_rd1", rd1_e, 32'hA);
        end
        step("stall_release", 1'b0, 1'b0, f);
        check32("release_rd1", rd1_e, 32'hB);

        // Flush wins over stall
        f = '0; f.valid = 1'b1; f.memwrite = 1'b1; f.rd1 = 32'h77;
        step("flush_and_stall", 1'b1, 1'b1, f);
        check32("flush_memwrite", {31'd0, memwrite_e}, 32'd0);
        check32("flush_valid", {31'd0, valid_e}, 32'd0);
        check32("flush_rd1", rd1_e, 32'd0);

        // Invalid slot: control sanitised, data kept
        f = '0; f.valid = 1'b0; f.regwrite = 1'b1; f.jump = 1'b1; f.rd2 = 32'h55;
        step("invalid_slot", 1'b0, 1'b0, f);
        check32("invalid_regwrite", {31'd0, regwrite_e}, 32'd0);
        check32("invalid_rd2", rd2_e, 32'h55);

        // Reset asserted during a stall, then a normal load
        f = all1;
        step("pre_stall_load", 1'b0, 1'b0, f);
        stall_e = 1'b1;
        pulse_rst();
        f = '0; f.valid = 1'b1; f.branch = 1'b1; f.signimm = 32'hFFFF_FFF0;
        step("load_after_reset", 1'b0, 1'b0, f);

        // Random mix of loads, stalls and flushes
        for (int i = 0; i < 40; i++) begin
            step("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 rand_fld());
        end

`ifdef IDEX_BUBBLE_CNT_EN
        // Four flushes plus one invalid load from a cleared counter
        pulse_rst();
        f = all1;
        for (int i = 0; i < 4; i++) step("cnt_flush", 1'($urandom), 1'b1, f);
        step("cnt_stall_nochg", 1'b1, 1'b0, '0);
        f = '0;
        step("cnt_invalid", 1'b0, 1'b0, f);
        check32("bubble_cnt_5", bubble_cnt_obs, 32'd5);

        // Saturation
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        step("cnt_sat_flush", 1'b0, 1'b1, all1);
        check32("bubble_cnt_sat", bubble_cnt_obs, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
